// File: rtl/arb_pkg.sv
// Shared encodings for the SRAM-like fetch/data arbiter: FSM states, owner tags
// and the starvation counter width.
package arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Fetch anti-starvation policy: counts data grants taken while fetch waits and
// forces a fetch win once the limit is reached.
module arb_starve_ctr
    import arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_inst,
    input  logic grant_data,
    input  logic inst_waiting,
    output logic force_inst
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;

    // Data grants with no fetch pending are free and leave the count alone.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (grant_inst)
            starve_cnt <= '0;
        else if (grant_data && inst_waiting && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign force_inst = (starve_cnt == LIMIT);

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between fetch and data sides; data has
// priority, one transaction outstanding, fetch protected from starvation.
module sram_like_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        state;
    arb_owner_t        owner;
    logic              mem_req_q;
    logic              lat_wr;
    logic [3:0]        lat_wstrb;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              force_inst;
    logic              grant_inst;
    logic              grant_data;
    logic              resp_fire;

    // Data wins ties unless the starvation counter has saturated.
    assign grant_inst = !rst && state == S_IDLE && inst_req && (!data_req || force_inst);
    assign grant_data = !rst && state == S_IDLE && data_req && !grant_inst;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .grant_inst  (grant_inst),
        .grant_data  (grant_data),
        .inst_waiting(inst_req),
        .force_inst  (force_inst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= OWN_INST;
            mem_req_q <= 1'b0;
            lat_wr    <= 1'b0;
            lat_wstrb <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_inst) begin
                        owner     <= OWN_INST;
                        lat_wr    <= 1'b0;
                        lat_wstrb <= '0;
                        lat_addr  <= inst_addr;
                        lat_wdata <= '0;
                        mem_req_q <= 1'b1;
                        state     <= S_REQ;
                    end else if (grant_data) begin
                        owner     <= OWN_DATA;
                        lat_wr    <= data_wr;
                        lat_wstrb <= data_wstrb;
                        lat_addr  <= data_addr;
                        lat_wdata <= data_wdata;
                        mem_req_q <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_addr_ok) begin
                        mem_req_q <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (mem_data_ok)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign resp_fire    = !rst && state == S_RESP && mem_data_ok;
    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = resp_fire && owner == OWN_INST;
    assign data_data_ok = resp_fire && owner == OWN_DATA;
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    // Registered request fields are masked so the port reads all-zero during reset.
    assign mem_req   = !rst && mem_req_q;
    assign mem_wr    = !rst && lat_wr;
    assign mem_wstrb = rst ? '0 : lat_wstrb;
    assign mem_addr  = rst ? '0 : lat_addr;
    assign mem_wdata = rst ? '0 : lat_wdata;
    assign busy      = !rst && state != S_IDLE;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus a random
// run checked against a transaction-level model of the arbitration rules.
module tb_sram_like_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int failures = 0;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change at negedge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1; inst_req = 1; data_req = 1; mem_data_ok = 1; mem_rdata = 32'h5555AAAA;
        #1;
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, busy} !== 6'b0 ||
            inst_rdata !== 0 || data_rdata !== 0) begin
            failures++;
            $display("FAIL reset_outputs: ctrl=%b rdata=%h/%h expected all zero",
                     {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, busy},
                     inst_rdata, data_rdata);
        end
        tick();
        clear_inputs(); rst = 0;
        data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h80000100; data_wdata = 32'hCAFEF00D;
        tick();
        data_req = 0; mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; rst = 1;
        #1;
        checks++;
        if (mem_req !== 0 || mem_addr !== 0 || mem_wr !== 0 || mem_wstrb !== 0 || mem_wdata !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL reset_during_rst: mem_req=%b addr=%h wr=%b wstrb=%h wdata=%h busy=%b expected all 0",
                     mem_req, mem_addr, mem_wr, mem_wstrb, mem_wdata, busy);
        end
        tick();
        rst = 0; mem_data_ok = 1; mem_rdata = 32'h11112222;
        #1;
        checks++;
        if (data_data_ok !== 0 || data_rdata !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL reset_mid_resp: data_data_ok=%b rdata=%h busy=%b expected 0/0/0",
                     data_data_ok, data_rdata, busy);
        end
        checks++;
        if (mem_req !== 0 || mem_addr !== 0 || mem_wr !== 0 || mem_wstrb !== 0 || mem_wdata !== 0) begin
            failures++;
            $display("FAIL reset_mem_clear: mem_req=%b addr=%h wr=%b wstrb=%h wdata=%h expected all 0",
                     mem_req, mem_addr, mem_wr, mem_wstrb, mem_wdata);
        end
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_lone_fetch();
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00000;
        #1;
        checks++;
        if (inst_addr_ok !== 1 || data_addr_ok !== 0) begin
            failures++;
            $display("FAIL fetch_accept: inst_addr_ok=%b data_addr_ok=%b expected 1/0", inst_addr_ok, data_addr_ok);
        end
        tick();
        inst_addr = 32'hBFC00004; mem_addr_ok = 1;
        #1;
        checks++;
        if (mem_req !== 1 || mem_addr !== 32'hBFC00000 || mem_wr !== 0 || mem_wstrb !== 0 || inst_addr_ok !== 0) begin
            failures++;
            $display("FAIL fetch_mem_req: req=%b addr=%h wr=%b wstrb=%h addr_ok=%b expected 1/bfc00000/0/0/0",
                     mem_req, mem_addr, mem_wr, mem_wstrb, inst_addr_ok);
        end
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h24010001;
        #1;
        checks++;
        if (inst_data_ok !== 1 || inst_rdata !== 32'h24010001 || data_data_ok !== 0 || mem_req !== 0 || inst_addr_ok !== 0) begin
            failures++;
            $display("FAIL fetch_data: data_ok=%b rdata=%h d_ok=%b mem_req=%b addr_ok=%b expected 1/24010001/0/0/0",
                     inst_data_ok, inst_rdata, data_data_ok, mem_req, inst_addr_ok);
        end
        tick();
        mem_data_ok = 0;
        #1;
        checks++;
        if (inst_addr_ok !== 1 || busy !== 0) begin
            failures++;
            $display("FAIL fetch_next_accept: inst_addr_ok=%b busy=%b expected 1/0", inst_addr_ok, busy);
        end
        tick();
        inst_req = 0; mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1;
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00100;
        data_req = 1; data_wr = 1; data_addr = 32'h80000010; data_wstrb = 4'b0011; data_wdata = 32'h1234ABCD;
        #1;
        checks++;
        if (data_addr_ok !== 1 || inst_addr_ok !== 0) begin
            failures++;
            $display("FAIL tie_data_first: data_addr_ok=%b inst_addr_ok=%b expected 1/0", data_addr_ok, inst_addr_ok);
        end
        tick();
        data_req = 0; mem_addr_ok = 1;
        #1;
        checks++;
        if (mem_wr !== 1 || mem_wstrb !== 4'b0011 || mem_addr !== 32'h80000010 || mem_wdata !== 32'h1234ABCD || inst_addr_ok !== 0) begin
            failures++;
            $display("FAIL tie_store_fields: wr=%b wstrb=%b addr=%h wdata=%h inst_ok=%b expected 1/0011/80000010/1234abcd/0",
                     mem_wr, mem_wstrb, mem_addr, mem_wdata, inst_addr_ok);
        end
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0;
        #1;
        checks++;
        if (data_data_ok !== 1 || inst_data_ok !== 0) begin
            failures++;
            $display("FAIL tie_write_done: data_data_ok=%b inst_data_ok=%b expected 1/0", data_data_ok, inst_data_ok);
        end
        tick();
        mem_data_ok = 0;
        #1;
        checks++;
        if (inst_addr_ok !== 1) begin
            failures++;
            $display("FAIL tie_inst_second: inst_addr_ok=%b expected 1", inst_addr_ok);
        end
        tick();
        inst_req = 0;
        #1;
        checks++;
        if (mem_addr !== 32'hBFC00100 || mem_wr !== 0 || mem_wstrb !== 0 || mem_req !== 1) begin
            failures++;
            $display("FAIL tie_inst_fields: addr=%h wr=%b wstrb=%b req=%b expected bfc00100/0/0000/1",
                     mem_addr, mem_wr, mem_wstrb, mem_req);
        end
        mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1;
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_starvation();
        string got = "";
        string want = "DDDDIDDDDI";
        int    n = 0;
        do_reset();
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        for (int c = 0; c < 60 && n < 10; c++) begin
            inst_addr = $urandom; data_addr = $urandom; data_wdata = $urandom;
            data_wr = $urandom_range(0, 1); data_wstrb = 4'($urandom);
            #1;
            if (inst_addr_ok && data_addr_ok) begin
                got = {got, "X"}; n++;
            end else if (data_addr_ok) begin
                got = {got, "D"}; n++;
            end else if (inst_addr_ok) begin
                got = {got, "I"}; n++;
            end
            tick();
        end
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL starvation_order: grants=%s expected %s", got, want);
        end
        clear_inputs();
        tick();
        tick();
        tick();
    endtask

    task automatic test_slow_mem();
        bit ok = 1;
        do_reset();
        data_req = 1; data_wr = 0; data_addr = 32'h80000040;
        tick();
        data_req = 0; inst_req = 1; inst_addr = 32'hBFC00200;
        for (int i = 0; i < 5; i++) begin
            mem_addr_ok = 0; mem_data_ok = (i == 2); mem_rdata = 32'hBAD0BAD0;
            #1;
            checks++;
            if (mem_req !== 1 || mem_addr !== 32'h80000040 || mem_wr !== 0 || inst_addr_ok !== 0 ||
                data_data_ok !== 0 || inst_data_ok !== 0) begin
                failures++; ok = 0;
                $display("FAIL slow_mem_hold[%0d]: req=%b addr=%h wr=%b i_ok=%b d_dok=%b i_dok=%b expected 1/80000040/0/0/0/0",
                         i, mem_req, mem_addr, mem_wr, inst_addr_ok, data_data_ok, inst_data_ok);
            end
            tick();
        end
        mem_addr_ok = 1; mem_data_ok = 0;
        tick();
        mem_addr_ok = 0;
        #1;
        checks++;
        if (mem_req !== 0 || busy !== 1 || data_data_ok !== 0 || inst_addr_ok !== 0) begin
            failures++;
            $display("FAIL slow_mem_resp_wait: req=%b busy=%b d_dok=%b i_ok=%b expected 0/1/0/0",
                     mem_req, busy, data_data_ok, inst_addr_ok);
        end
        tick();
        mem_data_ok = 1; mem_rdata = 32'h0BADCAFE;
        #1;
        checks++;
        if (data_data_ok !== 1 || data_rdata !== 32'h0BADCAFE) begin
            failures++;
            $display("FAIL slow_mem_data: d_dok=%b rdata=%h expected 1/0badcafe", data_data_ok, data_rdata);
        end
        tick();
        mem_data_ok = 0;
        #1;
        checks++;
        if (inst_addr_ok !== 1) begin
            failures++;
            $display("FAIL slow_mem_inst_after: inst_addr_ok=%b expected 1", inst_addr_ok);
        end
        tick();
        inst_req = 0; mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1;
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_read_routing();
        do_reset();
        data_req = 1; data_wr = 0; data_addr = 32'h80000020;
        tick();
        data_req = 0; mem_addr_ok = 1;
        tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (data_data_ok !== 1 || data_rdata !== 32'hDEADBEEF || inst_data_ok !== 0 || inst_rdata !== 0) begin
            failures++;
            $display("FAIL read_routing: d_dok=%b d_rdata=%h i_dok=%b i_rdata=%h expected 1/deadbeef/0/0",
                     data_data_ok, data_rdata, inst_data_ok, inst_rdata);
        end
        tick();
        // Stray response while idle must not reach either side.
        mem_rdata = 32'h77777777;
        #1;
        checks++;
        if (data_data_ok !== 0 || inst_data_ok !== 0 || data_rdata !== 0 || inst_rdata !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL stray_idle_data_ok: d_dok=%b i_dok=%b rdata=%h/%h busy=%b expected all 0",
                     data_data_ok, inst_data_ok, data_rdata, inst_rdata, busy);
        end
        tick();
        mem_data_ok = 0;
    endtask

    task automatic test_random();
        int          phase = 0;       // 0 idle, 1 awaiting accept, 2 awaiting response
        bit          own_data = 0;
        int          starve = 0;
        logic [31:0] e_addr = 0, e_wdata = 0;
        logic        e_wr = 0;
        logic [3:0]  e_wstrb = 0;
        bit          gi, gd, dok;
        logic [5:0]  exp_ctrl;
        logic [63:0] exp_rd;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!inst_req) begin
                if ($urandom_range(0, 1) == 1) begin inst_req = 1; inst_addr = $urandom; end
            end else if ($urandom_range(0, 15) == 0) inst_req = 0;
            if (!data_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    data_req = 1; data_addr = $urandom; data_wdata = $urandom;
                    data_wr = $urandom_range(0, 1); data_wstrb = 4'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) data_req = 0;
            mem_addr_ok = ($urandom_range(0, 2) == 0);
            mem_data_ok = ($urandom_range(0, 1) == 1);
            mem_rdata   = $urandom;

            gi  = (phase == 0) && inst_req && (!data_req || starve == LIMIT);
            gd  = (phase == 0) && data_req && !gi;
            dok = (phase == 2) && mem_data_ok;
            exp_ctrl = {gi, gd, dok && !own_data, dok && own_data, phase == 1, phase != 0};
            exp_rd   = {(dok && !own_data) ? mem_rdata : 32'h0, (dok && own_data) ? mem_rdata : 32'h0};
            #1;
            checks++;
            if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, busy} !== exp_ctrl) begin
                failures++;
                $display("FAIL rand_ctrl cyc=%0d: got %b expected %b (iaok daok idok ddok mreq busy)", cyc,
                         {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, busy}, exp_ctrl);
            end
            checks++;
            if ({inst_rdata, data_rdata} !== exp_rd) begin
                failures++;
                $display("FAIL rand_rdata cyc=%0d: got %h expected %h", cyc, {inst_rdata, data_rdata}, exp_rd);
            end
            if (phase == 1) begin
                checks++;
                if ({mem_addr, mem_wr, mem_wstrb, mem_wdata} !== {e_addr, e_wr, e_wstrb, e_wdata}) begin
                    failures++;
                    $display("FAIL rand_mem_fields cyc=%0d: got %h/%b/%b/%h expected %h/%b/%b/%h", cyc,
                             mem_addr, mem_wr, mem_wstrb, mem_wdata, e_addr, e_wr, e_wstrb, e_wdata);
                end
            end

            if (gi) begin
                own_data = 0; e_addr = inst_addr; e_wr = 0; e_wstrb = 0; e_wdata = 0;
                starve = 0; phase = 1;
            end else if (gd) begin
                own_data = 1; e_addr = data_addr; e_wr = data_wr; e_wstrb = data_wstrb; e_wdata = data_wdata;
                if (inst_req && starve < LIMIT) starve++;
                phase = 1;
            end else if (phase == 1 && mem_addr_ok) phase = 2;
            else if (dok) phase = 0;
            tick();
            if (gi) inst_req = 0;
            if (gd) data_req = 0;
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_starvation();
        test_slow_mem();
        test_read_routing();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
